// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and execute-side resolution signals between the core and the predictor.
interface branch_predictor_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] if_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              ex_valid;
    logic [ADDR_W-1:0] ex_pc;
    logic              ex_is_branch;
    logic              ex_is_jump;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_target;
    logic              ex_pred_taken;
    logic [ADDR_W-1:0] ex_pred_target;
    logic              flush;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  mispred_cnt;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_taken,
               ex_target, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, flush, redirect_pc, mispred_cnt
    );
    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_taken,
               ex_target, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, flush, redirect_pc, mispred_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit counter predictor: IF lookup, EX resolution/redirect,
// table training and a saturating misprediction counter.
module branch_predictor #(
    parameter int         ENTRIES  = 16,
    parameter int         ADDR_W   = 32,
    parameter int         CNT_W    = 16,
    parameter logic [1:0] INIT_CTR = 2'b10
) (
    input  logic               i_clk,
    input  logic               i_rst,
    branch_predictor_if.slave  bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [ADDR_W-1:0] r_target [ENTRIES];
    logic              r_jmp    [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];
    logic [CNT_W-1:0]  r_cnt;

    logic [IDX_W-1:0] w_if_idx, w_ex_idx;
    logic [TAG_W-1:0] w_if_tag, w_ex_tag;
    logic             w_if_hit, w_ex_hit, w_ex_act, w_mispred, w_upd, w_alloc;
    logic             w_unused;

    assign w_if_idx = bp.if_pc[IDX_W+1:2];
    assign w_if_tag = bp.if_pc[ADDR_W-1:IDX_W+2];
    assign w_ex_idx = bp.ex_pc[IDX_W+1:2];
    assign w_ex_tag = bp.ex_pc[ADDR_W-1:IDX_W+2];
    assign w_unused = ^{bp.if_pc[1:0], bp.ex_pc[1:0]};

    // Lookup reads the registered tables only; a same-cycle write is seen next cycle.
    assign w_if_hit       = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign bp.pred_taken  = w_if_hit && (r_jmp[w_if_idx] || r_ctr[w_if_idx][1]);
    assign bp.pred_target = bp.pred_taken ? r_target[w_if_idx] : bp.if_pc + ADDR_W'(4);

    assign w_ex_act       = bp.ex_valid && (bp.ex_is_branch || bp.ex_is_jump);
    assign w_mispred      = (bp.ex_taken != bp.ex_pred_taken) ||
                            (bp.ex_taken && (bp.ex_target != bp.ex_pred_target));
    assign bp.flush       = w_ex_act && w_mispred;
    assign bp.redirect_pc = bp.ex_taken ? bp.ex_target : bp.ex_pc + ADDR_W'(4);

    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_upd    = w_ex_act && w_ex_hit;
    assign w_alloc  = w_ex_act && !w_ex_hit && bp.ex_taken;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
        end else if (w_alloc) begin
            r_valid[w_ex_idx] <= 1'b1;
            r_ctr[w_ex_idx]   <= bp.ex_is_jump ? 2'b11 : INIT_CTR;
        end else if (w_upd) begin
            if (bp.ex_taken && r_ctr[w_ex_idx] != 2'b11)
                r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
            else if (!bp.ex_taken && r_ctr[w_ex_idx] != 2'b00)
                r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
        end
    end

    // Payload fields are meaningless while valid=0, so they carry no reset.
    always_ff @(posedge i_clk) begin
        if (w_alloc) begin
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= bp.ex_target;
            r_jmp[w_ex_idx]    <= bp.ex_is_jump;
        end else if (w_upd) begin
            r_jmp[w_ex_idx] <= bp.ex_is_jump;
            if (bp.ex_taken)
                r_target[w_ex_idx] <= bp.ex_target;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (bp.flush && !(&r_cnt))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign bp.mispred_cnt = r_cnt;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed literal checks plus randomized traffic compared every cycle against a table model.
module tb_branch_predictor;
    localparam int ENT   = 16;
    localparam int SH    = $clog2(ENT) + 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    branch_predictor_if #(.ADDR_W(32), .CNT_W(CNT_W)) bpi ();

    branch_predictor #(.ENTRIES(ENT), .ADDR_W(32), .CNT_W(CNT_W), .INIT_CTR(2'b10)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bp    (bpi.slave)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: each slot remembers the full PC that owns it.
    typedef struct {
        bit          v;
        logic [31:0] owner;
        logic [31:0] tgt;
        bit          jmp;
        int          ctr;
    } ent_t;
    ent_t m[ENT];
    int   m_cnt   = 0;
    bit   started = 0;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % ENT);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        ent_t e;
        e = m[slot(pc)];
        return e.v && ((e.owner >> SH) == (pc >> SH));
    endfunction

    always @(negedge clk) begin
        int          i;
        bit          ptk, act, mp;
        logic [31:0] ptgt;
        act = bpi.ex_valid && (bpi.ex_is_branch || bpi.ex_is_jump);
        mp  = (bpi.ex_taken != bpi.ex_pred_taken) ||
              (bpi.ex_taken && bpi.ex_target != bpi.ex_pred_target);
        if (started) begin
            i    = slot(bpi.if_pc);
            ptk  = m_hit(bpi.if_pc) && (m[i].jmp || m[i].ctr >= 2);
            ptgt = ptk ? m[i].tgt : bpi.if_pc + 32'd4;
            chk("model_pred_taken", 32'(bpi.pred_taken), 32'(ptk));
            chk("model_pred_target", bpi.pred_target, ptgt);
            chk("model_flush", 32'(bpi.flush), 32'(act && mp));
            if (act && mp)
                chk("model_redirect", bpi.redirect_pc,
                    bpi.ex_taken ? bpi.ex_target : bpi.ex_pc + 32'd4);
            chk("model_cnt", 32'(bpi.mispred_cnt), 32'(m_cnt));
        end
        if (rst) begin
            for (int k = 0; k < ENT; k++) begin
                m[k].v   = 0;
                m[k].ctr = 1;
            end
            m_cnt   = 0;
            started = 1;
        end else if (act) begin
            i = slot(bpi.ex_pc);
            if (m_hit(bpi.ex_pc)) begin
                m[i].ctr = bpi.ex_taken ? ((m[i].ctr < 3) ? m[i].ctr + 1 : 3)
                                        : ((m[i].ctr > 0) ? m[i].ctr - 1 : 0);
                if (bpi.ex_taken) m[i].tgt = bpi.ex_target;
                m[i].jmp = bpi.ex_is_jump;
            end else if (bpi.ex_taken) begin
                m[i].v     = 1;
                m[i].owner = bpi.ex_pc;
                m[i].tgt   = bpi.ex_target;
                m[i].jmp   = bpi.ex_is_jump;
                m[i].ctr   = bpi.ex_is_jump ? 3 : 2;
            end
            if (mp && m_cnt < CMAX) m_cnt++;
        end
    end

    task automatic ex(input bit v, input bit br, input bit jp, input bit tk,
                      input logic [31:0] pc, input logic [31:0] tgt,
                      input bit ptk, input logic [31:0] ptgt);
        bpi.ex_valid       = v;
        bpi.ex_is_branch   = br;
        bpi.ex_is_jump     = jp;
        bpi.ex_taken       = tk;
        bpi.ex_pc          = pc;
        bpi.ex_target      = tgt;
        bpi.ex_pred_taken  = ptk;
        bpi.ex_pred_target = ptgt;
    endtask

    task automatic idle();
        ex(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] pc, input bit tk, input logic [31:0] tgt, input string nm);
        bpi.if_pc = pc;
        @(negedge clk);
        chk({nm, "_taken"}, 32'(bpi.pred_taken), 32'(tk));
        chk({nm, "_target"}, bpi.pred_target, tgt);
        nxt();
    endtask

    initial begin
        bpi.if_pc = 32'h100;
        idle();
        nxt(); nxt();
        @(negedge clk);
        chk("rst_taken", 32'(bpi.pred_taken), 32'd0);
        chk("rst_target", bpi.pred_target, 32'h104);
        chk("rst_cnt", 32'(bpi.mispred_cnt), 32'd0);
        nxt();
        rst = 0;

        // First taken resolution allocates with the weakly-taken counter.
        ex(1, 1, 0, 1, 32'h100, 32'h80, 0, 32'h104);
        @(negedge clk);
        chk("t2_flush", 32'(bpi.flush), 32'd1);
        chk("t2_redirect", bpi.redirect_pc, 32'h80);
        nxt(); idle();
        @(negedge clk);
        chk("t2_cnt", 32'(bpi.mispred_cnt), 32'd1);
        nxt();
        look(32'h100, 1, 32'h80, "t2_look");

        for (int n = 0; n < 2; n++) begin
            ex(1, 1, 0, 0, 32'h100, 32'h80, 1, 32'h80);
            @(negedge clk);
            chk("t3_flush", 32'(bpi.flush), 32'd1);
            chk("t3_redirect", bpi.redirect_pc, 32'h104);
            nxt();
        end
        idle();
        look(32'h100, 0, 32'h104, "t3_look");

        ex(1, 0, 1, 1, 32'h200, 32'h400, 0, 32'h204);
        bpi.if_pc = 32'h200;
        @(negedge clk);
        chk("t4_flush", 32'(bpi.flush), 32'd1);
        chk("t4_no_bypass", 32'(bpi.pred_taken), 32'd0);
        nxt(); idle();
        look(32'h200, 1, 32'h400, "t4_jal");
        ex(1, 1, 0, 1, 32'h240, 32'h500, 0, 32'h244);
        nxt(); idle();
        look(32'h200, 0, 32'h204, "t4_evicted");
        look(32'h240, 1, 32'h500, "t4_alias");

        ex(1, 1, 0, 1, 32'h240, 32'h500, 1, 32'h500);
        @(negedge clk);
        chk("t5_correct_flush", 32'(bpi.flush), 32'd0);
        nxt();
        ex(0, 1, 0, 0, 32'h240, 32'h80, 1, 32'h500);
        @(negedge clk);
        chk("t5_invalid_flush", 32'(bpi.flush), 32'd0);
        nxt(); idle();
        @(negedge clk);
        chk("t5_cnt", 32'(bpi.mispred_cnt), 32'd5);
        nxt();
        look(32'h240, 1, 32'h500, "t5_look");

        for (int n = 0; n < 11; n++) begin
            ex(1, 1, 0, 0, 32'h300, 32'h900, 1, 32'h900);
            nxt();
        end
        idle();
        @(negedge clk);
        chk("t6_sat", 32'(bpi.mispred_cnt), 32'(CMAX));
        nxt();
        rst = 1;
        nxt();
        rst = 0;
        look(32'h100, 0, 32'h104, "t6_rst_a");
        look(32'h200, 0, 32'h204, "t6_rst_b");
        look(32'h240, 0, 32'h244, "t6_rst_c");
        @(negedge clk);
        chk("t6_rst_cnt", 32'(bpi.mispred_cnt), 32'd0);
        nxt();

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc, tgt;
            int          kind;
            pc   = 32'($urandom_range(0, 47)) << 2;
            kind = int'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: tgt = 32'h40;
                1: tgt = 32'h80;
                2: tgt = 32'h400;
                default: tgt = 32'h1000;
            endcase
            bpi.if_pc = 32'($urandom_range(0, 47)) << 2;
            if (kind == 0)
                ex(0, 1, 0, $urandom_range(0, 1) == 1, pc, tgt, 0, pc + 32'd4);
            else if (kind == 1)
                ex(1, 0, 1, 1, pc, tgt, $urandom_range(0, 1) == 1,
                   ($urandom_range(0, 1) == 1) ? tgt : 32'h80);
            else
                ex(1, 1, 0, $urandom_range(0, 1) == 1, pc, tgt, $urandom_range(0, 1) == 1,
                   ($urandom_range(0, 2) != 0) ? tgt : pc + 32'd4);
            rst = ($urandom_range(0, 299) == 0);
            if (rst) bpi.ex_valid = 0;
            nxt();
        end
        rst = 0;
        idle();
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
